// File: rtl/serial_subtractor.sv
// serial_subtractor: bit-serial LSB-first two's-complement subtractor (d = a - b)
// with a single borrow flop, started and drained by a start/done handshake.
module serial_subtractor #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] d,
  output logic             bout,
  output logic             ovf
);
  localparam int CW = $clog2(WIDTH);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t           state_q;
  logic [WIDTH-1:0] sa_q, sb_q, d_q;
  logic [CW-1:0]    cnt_q;
  logic             borrow_q, bout_q, ovf_q, amsb_q, bmsb_q;
  logic             diff_bit, borrow_d;
  assign diff_bit = sa_q[0] ^ sb_q[0] ^ borrow_q;
  assign borrow_d = (~sa_q[0] & sb_q[0]) | (~(sa_q[0] ^ sb_q[0]) & borrow_q);
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      sa_q     <= '0;
      sb_q     <= '0;
      d_q      <= '0;
      cnt_q    <= '0;
      borrow_q <= 1'b0;
      bout_q   <= 1'b0;
      ovf_q    <= 1'b0;
      amsb_q   <= 1'b0;
      bmsb_q   <= 1'b0;
    end else if (state_q == RUN) begin
      sa_q     <= sa_q >> 1;
      sb_q     <= sb_q >> 1;
      d_q      <= {diff_bit, d_q[WIDTH-1:1]};
      borrow_q <= borrow_d;
      cnt_q    <= cnt_q + 1'b1;
      // last bit: diff_bit is the result MSB
      if (cnt_q == CW'(WIDTH - 1)) begin
        bout_q  <= borrow_d;
        ovf_q   <= (amsb_q != bmsb_q) && (diff_bit != amsb_q);
        state_q <= DONE;
      end
    end else if (start) begin
      sa_q     <= a;
      sb_q     <= b;
      amsb_q   <= a[WIDTH-1];
      bmsb_q   <= b[WIDTH-1];
      d_q      <= '0;
      cnt_q    <= '0;
      borrow_q <= 1'b0;
      bout_q   <= 1'b0;
      ovf_q    <= 1'b0;
      state_q  <= RUN;
    end else begin
      state_q  <= IDLE;
    end
  end
  assign busy = (state_q == RUN);
  assign done = (state_q == DONE);
  assign d    = d_q;
  assign bout = bout_q;
  assign ovf  = ovf_q;
endmodule
